cluster_frame_scheduler: RTL and testbench

CLUSTER_FRAME_SCHEDULER -- requirements
Module: cluster_frame_scheduler

---
 rtl/cluster_frame_scheduler.sv | 149 ++++++++++++++
 tb/tb_cluster_frame_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cluster_frame_scheduler.sv
// Buffers latched cluster frames in a two-entry FIFO and streams each frame out
// as MXCLUSTERS/2 two-cluster beats under valid/ready flow control.
module cluster_frame_scheduler #(
    parameter int MXCLUSTERS     = 8,
    parameter int LATCH_PERIOD   = 4,
    parameter bit SUPPRESS_EMPTY = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          bc0,
    output logic                          latch_pulse,
    input  logic                          latch_in,
    input  logic [11*MXCLUSTERS-1:0]      adr_in,
    input  logic [3*MXCLUSTERS-1:0]       cnt_in,
    input  logic [MXCLUSTERS-1:0]         vpf_in,
    output logic [27:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2((MXCLUSTERS/2) > 1 ? (MXCLUSTERS/2) : 2)-1:0] out_beat,
    output logic                          out_first,
    output logic                          overflow,
    output logic [15:0]                   overflow_cnt
);

    localparam int NBEATS = MXCLUSTERS / 2;
    localparam int BW     = $clog2(NBEATS > 1 ? NBEATS : 2);
    localparam int PW     = $clog2(LATCH_PERIOD);
    localparam logic [PW-1:0] PHASE_LAST = PW'(LATCH_PERIOD - 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(NBEATS - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [PW-1:0]              phase_q, phase_d;
    logic                       latchPulse_q;
    logic [11*MXCLUSTERS-1:0]   adrMem_q [2];
    logic [3*MXCLUSTERS-1:0]    cntMem_q [2];
    logic [MXCLUSTERS-1:0]      vpfMem_q [2];
    logic                       rdPtr_q, wrPtr_q;
    logic [1:0]                 count_q, count_d;
    logic [0:0]                 state_q, state_d;
    logic [BW-1:0]              beat_q, beat_d;
    logic                       overflow_q;
    logic [15:0]                overflowCnt_q;

    logic accept, lastBeat, pop, push, drop, frameKeep;
    logic [11*MXCLUSTERS-1:0]   headAdr;
    logic [3*MXCLUSTERS-1:0]    headCnt;
    logic [MXCLUSTERS-1:0]      headVpf;
    logic [13:0]                evenWord, oddWord;

    function automatic logic [13:0] mkWord(input logic v, input logic [2:0] c, input logic [10:0] a);
        return v ? {c, a} : {3'd0, 11'h7FE};
    endfunction

    // bc0 realigns the phase so the next strobe lands LATCH_PERIOD cycles later
    always_comb begin
        phase_d = bc0 ? '0 : ((phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q      <= '0;
            latchPulse_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            latchPulse_q <= (phase_q == PHASE_LAST);
        end
    end

    // A pop on the last beat frees a slot in time for a same-cycle write
    always_comb begin
        accept    = (state_q == SEND) && out_ready;
        lastBeat  = (beat_q == BEAT_LAST);
        pop       = accept && lastBeat;
        frameKeep = !SUPPRESS_EMPTY || (|vpf_in);
        push      = latch_in && frameKeep && ((count_q != 2'd2) || pop);
        drop      = latch_in && frameKeep && (count_q == 2'd2) && !pop;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (state_q == IDLE) begin
            if (count_q != 2'd0) begin
                state_d = SEND;
                beat_d  = '0;
            end
        end else if (accept) begin
            if (lastBeat) begin
                beat_d = '0;
                if (count_d == 2'd0) state_d = IDLE;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_comb begin
        headAdr  = adrMem_q[rdPtr_q];
        headCnt  = cntMem_q[rdPtr_q];
        headVpf  = vpfMem_q[rdPtr_q];
        evenWord = '0;
        oddWord  = '0;
        for (int b = 0; b < NBEATS; b++) begin
            if (beat_q == BW'(b)) begin
                evenWord = mkWord(headVpf[2*b],   headCnt[6*b +: 3],   headAdr[22*b +: 11]);
                oddWord  = mkWord(headVpf[2*b+1], headCnt[6*b+3 +: 3], headAdr[22*b+11 +: 11]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            adrMem_q[wrPtr_q] <= adr_in;
            cntMem_q[wrPtr_q] <= cnt_in;
            vpfMem_q[wrPtr_q] <= vpf_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q       <= 2'd0;
            rdPtr_q       <= 1'b0;
            wrPtr_q       <= 1'b0;
            state_q       <= IDLE;
            beat_q        <= '0;
            overflow_q    <= 1'b0;
            overflowCnt_q <= 16'd0;
        end else begin
            count_q    <= count_d;
            state_q    <= state_d;
            beat_q     <= beat_d;
            overflow_q <= drop;
            if (push) wrPtr_q <= ~wrPtr_q;
            if (pop)  rdPtr_q <= ~rdPtr_q;
            if (drop && overflowCnt_q != 16'hFFFF) overflowCnt_q <= overflowCnt_q + 16'd1;
        end
    end

    assign latch_pulse  = latchPulse_q;
    assign out_valid    = (state_q == SEND);
    assign out_data     = out_valid ? {oddWord, evenWord} : 28'd0;
    assign out_beat     = beat_q;
    assign out_first    = out_valid && (beat_q == '0);
    assign overflow     = overflow_q;
    assign overflow_cnt = overflowCnt_q;

endmodule

// File: tb/tb_cluster_frame_scheduler.sv
// Directed self-checking bench for cluster_frame_scheduler with default parameters.
`timescale 1ns/1ps
module tb_cluster_frame_scheduler;

    logic        clock = 1'b0;
    logic        reset, bc0, latch_in, out_ready;
    logic [87:0] adr_in;
    logic [23:0] cnt_in;
    logic [7:0]  vpf_in;
    logic        latch_pulse, out_valid, out_first, overflow;
    logic [27:0] out_data;
    logic [1:0]  out_beat;
    logic [15:0] overflow_cnt;

    int vectorsApplied = 0;
    int miscompares    = 0;

    logic [87:0] a;
    logic [23:0] c;
    logic [27:0] expData [8];

    cluster_frame_scheduler dut (
        .clock(clock), .reset(reset), .bc0(bc0), .latch_pulse(latch_pulse),
        .latch_in(latch_in), .adr_in(adr_in), .cnt_in(cnt_in), .vpf_in(vpf_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_beat(out_beat), .out_first(out_first), .overflow(overflow),
        .overflow_cnt(overflow_cnt)
    );

    always #3 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkBeat(input string tag, input logic [27:0] data, input logic [1:0] beat, input logic first);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"},  32'(out_data),  32'(data));
        checkOutput({tag, "_beat"},  32'(out_beat),  32'(beat));
        checkOutput({tag, "_first"}, 32'(out_first), 32'(first));
    endtask

    task automatic applyStimulus(input logic [7:0] vpf, input logic [87:0] adr, input logic [23:0] cnt);
        vpf_in   = vpf;
        adr_in   = adr;
        cnt_in   = cnt;
        latch_in = 1'b1;
        tick();
        latch_in = 1'b0;
    endtask

    function automatic logic [87:0] adrFill(input int base);
        logic [87:0] r;
        for (int i = 0; i < 8; i++) r[11*i +: 11] = 11'(base + i);
        return r;
    endfunction

    initial begin
        // Reset held with bc0 and latch_in active; reset must win
        reset = 1'b1; bc0 = 1'b1; latch_in = 1'b1; out_ready = 1'b0;
        adr_in = adrFill(1); cnt_in = 24'o77777777; vpf_in = 8'hFF;
        tick(); tick();
        checkOutput("rst_latch_pulse", 32'(latch_pulse), 32'd0);
        checkOutput("rst_out_valid",   32'(out_valid),   32'd0);
        checkOutput("rst_out_data",    32'(out_data),    32'd0);
        checkOutput("rst_out_beat",    32'(out_beat),    32'd0);
        checkOutput("rst_out_first",   32'(out_first),   32'd0);
        checkOutput("rst_overflow",    32'(overflow),    32'd0);
        checkOutput("rst_overflow_cnt", 32'(overflow_cnt), 32'd0);

        // Cadence: strobes at 4, then bc0 at 6 moves the next one to 10, then 14
        reset = 1'b0; latch_in = 1'b0; bc0 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            bc0 = (k == 6);
            tick();
            checkOutput($sformatf("cadence_%0d", k), 32'(latch_pulse), 32'(k == 4 || k == 10 || k == 14));
        end
        bc0 = 1'b0;
        checkOutput("no_frame_from_reset", 32'(out_valid), 32'd0);

        // Single frame with clusters 0 and 2 valid
        out_ready = 1'b1;
        a = adrFill(100); a[10:0] = 11'd10; a[32:22] = 11'd300;
        c = 24'o76543210; c[2:0] = 3'd2; c[8:6] = 3'd5;
        applyStimulus(8'h05, a, c);
        checkOutput("single_latency", 32'(out_valid), 32'd0);
        tick(); checkBeat("single_b0", {14'h07FE, 3'd2, 11'd10}, 2'd0, 1'b1);
        tick(); checkBeat("single_b1", {14'h07FE, 3'd5, 11'd300}, 2'd1, 1'b0);
        tick(); checkBeat("single_b2", {14'h07FE, 14'h07FE}, 2'd2, 1'b0);
        tick(); checkBeat("single_b3", {14'h07FE, 14'h07FE}, 2'd3, 1'b0);
        tick(); checkOutput("single_done", 32'(out_valid), 32'd0);

        // Back-pressure on beat 1 for three cycles
        applyStimulus(8'hFF, adrFill(20), 24'o76543210);
        tick(); checkBeat("bp_b0", {3'd1, 11'd21, 3'd0, 11'd20}, 2'd0, 1'b1);
        tick(); checkBeat("bp_b1", {3'd3, 11'd23, 3'd2, 11'd22}, 2'd1, 1'b0);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick(); checkBeat($sformatf("bp_stall%0d", s), {3'd3, 11'd23, 3'd2, 11'd22}, 2'd1, 1'b0);
        end
        out_ready = 1'b1;
        tick(); checkBeat("bp_b2", {3'd5, 11'd25, 3'd4, 11'd24}, 2'd2, 1'b0);
        tick(); checkBeat("bp_b3", {3'd7, 11'd27, 3'd6, 11'd26}, 2'd3, 1'b0);
        tick(); checkOutput("bp_done", 32'(out_valid), 32'd0);

        // Overflow: third frame dropped while stalled
        out_ready = 1'b0;
        applyStimulus(8'hFF, adrFill(40), 24'o11111111);
        a = '0; c = '0; a[10:0] = 11'd500; c[2:0] = 3'd7;
        applyStimulus(8'h01, a, c);
        checkOutput("ovf_none_yet", 32'(overflow), 32'd0);
        a = '0; c = '0; a[87:77] = 11'd999; c[23:21] = 3'd2;
        applyStimulus(8'h80, a, c);
        checkOutput("ovf_pulse", 32'(overflow), 32'd1);
        checkOutput("ovf_cnt", 32'(overflow_cnt), 32'd1);
        tick();
        checkOutput("ovf_pulse_end", 32'(overflow), 32'd0);
        checkOutput("ovf_cnt_hold", 32'(overflow_cnt), 32'd1);
        for (int b = 0; b < 4; b++) begin
            expData[b]   = {3'd1, 11'(41 + 2*b), 3'd1, 11'(40 + 2*b)};
            expData[b+4] = {14'h07FE, 14'h07FE};
        end
        expData[4] = {14'h07FE, 3'd7, 11'd500};
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checkBeat($sformatf("ovf_beat%0d", j), expData[j], 2'(j % 4), (j % 4) == 0);
            tick();
        end
        checkOutput("ovf_done", 32'(out_valid), 32'd0);

        // Last beat accepted together with latch_in on a full FIFO
        out_ready = 1'b0;
        a = '0; c = '0; a[21:11] = 11'd33; c[5:3] = 3'd3;
        applyStimulus(8'h02, a, c);
        a = '0; c = '0; a[54:44] = 11'd1234; c[14:12] = 3'd6;
        applyStimulus(8'h10, a, c);
        out_ready = 1'b1;
        checkBeat("sim_d0", {3'd3, 11'd33, 14'h07FE}, 2'd0, 1'b1);
        tick(); tick(); tick();
        checkBeat("sim_d3", {14'h07FE, 14'h07FE}, 2'd3, 1'b0);
        a = '0; c = '0; a[76:66] = 11'd7; c[20:18] = 3'd1; a[87:77] = 11'd2047; c[23:21] = 3'd4;
        applyStimulus(8'hC0, a, c);
        checkOutput("sim_no_ovf", 32'(overflow), 32'd0);
        checkOutput("sim_cnt", 32'(overflow_cnt), 32'd1);
        for (int j = 0; j < 8; j++) expData[j] = {14'h07FE, 14'h07FE};
        expData[2] = {14'h07FE, 3'd6, 11'd1234};
        expData[7] = {3'd4, 11'd2047, 3'd1, 11'd7};
        for (int j = 0; j < 8; j++) begin
            checkBeat($sformatf("sim_beat%0d", j), expData[j], 2'(j % 4), (j % 4) == 0);
            tick();
        end
        checkOutput("sim_done", 32'(out_valid), 32'd0);

        // Empty frame suppressed
        applyStimulus(8'h00, adrFill(5), 24'o12345670);
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("empty_%0d", s), 32'(out_valid), 32'd0);
            tick();
        end

        // Reset on beat 2 with a second frame queued
        applyStimulus(8'hFF, adrFill(60), 24'o22222222);
        applyStimulus(8'hFF, adrFill(80), 24'o33333333);
        tick(); tick();
        checkBeat("rst_mid_b2", {3'd2, 11'd65, 3'd2, 11'd64}, 2'd2, 1'b0);
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_data", 32'(out_data), 32'd0);
        checkOutput("rst_mid_cnt", 32'(overflow_cnt), 32'd0);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            checkOutput($sformatf("post_rst_%0d", s), 32'(out_valid), 32'd0);
        end
        a = '0; c = '0; a[10:0] = 11'd77; c[2:0] = 3'd3;
        applyStimulus(8'h01, a, c);
        checkOutput("restart_latency", 32'(out_valid), 32'd0);
        tick();
        checkBeat("restart_b0", {14'h07FE, 3'd3, 11'd77}, 2'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
